// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the registered signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    // Single full-subtractor stage plus the result shifted in from the top
    always_comb begin
        w_d        = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));
        w_accept   = start && (r_state != SHIFT);
    end

    // Control FSM with datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            unique case (r_state)
                SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= DONE;
                        diff    <= w_res_next;
                        bout    <= w_br_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= SHIFT;
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        done    <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    // Operand sign bits survive the shifting so overflow can be judged at the end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
            end
            if (r_state == SHIFT && r_cnt == LAST) begin
                ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_res_next[WIDTH-1]);
            end
        end
    end
`endif

endmodule
